// File: rtl/pll_lock_sequencer_pkg.sv
// pll_lock_sequencer_pkg: state encoding, debug widths and counter sizing shared by the PLL lock sequencer
package pll_lock_sequencer_pkg;
  typedef enum logic [2:0] {
    ST_RST_HOLD  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;
  localparam int LOST_W = 8;
  function automatic int cnt_w(input int terminal);
    return terminal < 2 ? 1 : $clog2(terminal);
  endfunction
endpackage

// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if: PLL control/status and debug bundle between the sequencer and the PLL/board side
interface pll_lock_sequencer_if #(parameter int RW = 2);
  import pll_lock_sequencer_pkg::*;
  logic PLL_LOCK, RESTART, PLL_RESETB, PLL_BYPASS, READY, FAULT;
  logic [RW-1:0] RETRY_COUNT;
  logic [LOST_W-1:0] LOST_COUNT;
  logic [2:0] STATE;
  modport master (
    input PLL_LOCK, RESTART,
    output PLL_RESETB, PLL_BYPASS, READY, FAULT, RETRY_COUNT, LOST_COUNT, STATE
  );
  modport slave (
    output PLL_LOCK, RESTART,
    input PLL_RESETB, PLL_BYPASS, READY, FAULT, RETRY_COUNT, LOST_COUNT, STATE
  );
endinterface

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: two-flop synchroniser for an asynchronous status input
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);
  logic meta_q, sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {sync_q, meta_q} <= '0;
    else {sync_q, meta_q} <= {meta_q, async_i};
  assign sync_o = sync_q;
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: sequences SB_PLL40_CORE reset release, waits for and qualifies LOCK,
// retries on timeout, latches FAULT when retries run out and re-locks after lock loss.
module pll_lock_sequencer
  import pll_lock_sequencer_pkg::*;
#(
  parameter int RESET_CYCLES    = 16,
  parameter int LOCK_TIMEOUT    = 4096,
  parameter int LOCK_STABLE     = 64,
  parameter int MAX_RETRIES     = 3,
  parameter bit BYPASS_ON_FAULT = 1'b1
) (
  input logic REFERENCECLK,
  input logic RESET,
  pll_lock_sequencer_if.master bus
);
  localparam int HW = cnt_w(RESET_CYCLES);
  localparam int TW = cnt_w(LOCK_TIMEOUT);
  localparam int SW = cnt_w(LOCK_STABLE);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  state_e state_q, state_d, retry_st;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] to_q, to_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [LOST_W-1:0] lost_q, lost_d;
  logic resetb_q, resetb_d, bypass_q, bypass_d, ready_q, ready_d, fault_q, fault_d;
  logic lock_s, timeout, give_up, tmo_hit, att_q, att_d;
  pll_lock_sync u_sync (
    .clk    (REFERENCECLK),
    .rst_n  (RESET),
    .async_i(bus.PLL_LOCK),
    .sync_o (lock_s)
  );
  always_comb begin
    timeout  = to_q == TW'(LOCK_TIMEOUT - 1);
    give_up  = retry_q == RW'(MAX_RETRIES - 1);
    retry_st = give_up ? ST_FAULT : ST_RST_HOLD;
    state_d  = state_q;
    case (state_q)
      ST_RST_HOLD:  state_d = hold_q == HW'(RESET_CYCLES - 1) ? ST_WAIT_LOCK : ST_RST_HOLD;
      ST_WAIT_LOCK: state_d = lock_s ? ST_STABLE : timeout ? retry_st : ST_WAIT_LOCK;
      ST_STABLE:    state_d = timeout ? retry_st : !lock_s ? ST_WAIT_LOCK :
                              stab_q == SW'(LOCK_STABLE - 1) ? ST_RUN : ST_STABLE;
      ST_RUN:       state_d = lock_s ? ST_RUN : ST_RST_HOLD;
      ST_FAULT:     state_d = ST_FAULT;
      default:      state_d = ST_RST_HOLD;
    endcase
    if (bus.RESTART) state_d = ST_RST_HOLD;
    tmo_hit = !bus.RESTART && timeout &&
              (state_q == ST_STABLE || (state_q == ST_WAIT_LOCK && !lock_s));
    // to_cnt spans the whole attempt (WAIT_LOCK and STABLE) and saturates at its terminal value
    att_q    = state_q inside {ST_WAIT_LOCK, ST_STABLE};
    att_d    = state_d inside {ST_WAIT_LOCK, ST_STABLE};
    hold_d   = (state_q == ST_RST_HOLD && state_d == ST_RST_HOLD && !bus.RESTART) ? hold_q + 1'b1 : '0;
    to_d     = (att_q && att_d) ? (timeout ? to_q : to_q + 1'b1) : '0;
    stab_d   = (state_q == ST_STABLE && state_d == ST_STABLE) ? stab_q + 1'b1 : '0;
    retry_d  = (bus.RESTART || state_d == ST_RUN) ? '0 : (tmo_hit && !give_up) ? retry_q + 1'b1 : retry_q;
    lost_d   = (state_q == ST_RUN && !lock_s && !bus.RESTART && lost_q != '1) ? lost_q + 1'b1 : lost_q;
    resetb_d = state_d inside {ST_WAIT_LOCK, ST_STABLE, ST_RUN};
    // READY rises one cycle into RUN but drops on the very edge that leaves it
    ready_d  = state_q == ST_RUN && state_d == ST_RUN;
    fault_d  = state_d == ST_FAULT;
    bypass_d = fault_d & BYPASS_ON_FAULT;
  end
  always_ff @(posedge REFERENCECLK or negedge RESET)
    if (!RESET) begin
      state_q  <= ST_RST_HOLD;
      hold_q   <= '0;
      to_q     <= '0;
      stab_q   <= '0;
      retry_q  <= '0;
      lost_q   <= '0;
      resetb_q <= 1'b0;
      bypass_q <= 1'b0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      to_q     <= to_d;
      stab_q   <= stab_d;
      retry_q  <= retry_d;
      lost_q   <= lost_d;
      resetb_q <= resetb_d;
      bypass_q <= bypass_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  assign bus.PLL_RESETB  = resetb_q;
  assign bus.PLL_BYPASS  = bypass_q;
  assign bus.READY       = ready_q;
  assign bus.FAULT       = fault_q;
  assign bus.RETRY_COUNT = retry_q;
  assign bus.LOST_COUNT  = lost_q;
  assign bus.STATE       = state_q;
endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Controller for the iCE40 SB_PLL40_CORE clock generator (12 MHz in, 96 MHz out). It sequences PLL reset release, waits for LOCK with a timeout, and qualifies lock as stable before releasing the downstream READY. It retries on timeout, escalates to FAULT after too many retries, and restarts the sequence if lock is lost. It runs in the REFERENCECLK domain and sits between the board reset and the PLL wrapper.

Parameters:
RESET_CYCLES, 16, cycles PLL_RESETB is held low per attempt (min 1)
LOCK_TIMEOUT, 4096, cycles allowed from PLL reset release to stable lock (min 2)
LOCK_STABLE, 64, consecutive synchronised-lock cycles required before READY (min 1)
MAX_RETRIES, 3, failed attempts tolerated before FAULT (min 1)
BYPASS_ON_FAULT, 1, 1 = drive PLL_BYPASS high while in FAULT

Ports:
REFERENCECLK  in  1  12 MHz reference clock; sole clock
RESET  in  1  asynchronous, active-low reset
PLL_LOCK  in  1  raw LOCK from PLL; asynchronous, synchronised internally
RESTART  in  1  synchronous pulse; requests a full re-lock sequence
PLL_RESETB  out  1  to PLL RESETB; active low
PLL_BYPASS  out  1  to PLL BYPASS
READY  out  1  high only while PLL is locked and qualified
FAULT  out  1  sticky; retries exhausted
RETRY_COUNT  out  clog2(MAX_RETRIES+1)  failed attempts in the current sequence
LOST_COUNT  out  8  count of lock-loss events in RUN; saturates at 255
STATE  out  3  current FSM state, for debug

Behaviour:
- Reset (RESET low, async): state=RST_HOLD, PLL_RESETB=0, PLL_BYPASS=0, READY=0, FAULT=0, RETRY_COUNT=0, LOST_COUNT=0, all counters=0, sync flops=0.
- PLL_LOCK passes through a 2-flop synchroniser (lock_s). The FSM uses only lock_s.
- All outputs are registered and reflect the current state. Encoding: RST_HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- RST_HOLD: PLL_RESETB=0. hold_cnt counts 0..RESET_CYCLES-1, then go to WAIT_LOCK and clear to_cnt.
- WAIT_LOCK: PLL_RESETB=1. to_cnt increments each cycle.
  - lock_s=1: go to STABLE and clear stab_cnt.
  - Otherwise, if to_cnt reaches LOCK_TIMEOUT-1: this is a timeout.
- STABLE: PLL_RESETB=1. to_cnt keeps running and is not cleared. stab_cnt increments while lock_s=1.
  - lock_s=0: return to WAIT_LOCK; stab_cnt is cleared, to_cnt is not.
  - stab_cnt reaches LOCK_STABLE-1 with lock_s=1: go to RUN.
  - to_cnt reaches LOCK_TIMEOUT-1: timeout. Timeout takes priority over the RUN transition in the same cycle.
- Timeout: if RETRY_COUNT==MAX_RETRIES-1, go to FAULT. Otherwise increment RETRY_COUNT and go to RST_HOLD.
- RUN: READY=1, PLL_RESETB=1, RETRY_COUNT cleared on entry.
  - lock_s=0: go to RST_HOLD and increment LOST_COUNT (saturating). READY falls on that same transition edge.
- FAULT: PLL_RESETB=0, FAULT=1, PLL_BYPASS=BYPASS_ON_FAULT, READY=0. The only exits are RESTART or RESET.
- RESTART=1 in any state: go to RST_HOLD; clear FAULT, RETRY_COUNT, hold_cnt, to_cnt and stab_cnt; PLL_BYPASS=0. RESTART has priority over all other transitions. LOST_COUNT is not cleared.
- READY latency: PLL_LOCK first sampled high at edge N (stays high) → READY high after edge N+2+LOCK_STABLE+1.
- Lock glitch during STABLE restarts qualification; READY never pulses.
- RESET asserted mid-sequence: immediate async return to reset values, including PLL_RESETB=0.
- Counter widths: clog2 of each terminal value. No counter ever wraps; each is cleared on state entry as specified.

Decomposition:
- Shared include file pll_seq_defs: state encodings and LOST_COUNT width.
- One sub-module, pll_lock_sync: 2-flop synchroniser with async active-low reset, reused for any async status input.
- FSM, counters and output registers stay in pll_lock_sequencer.

Test Plan:
All scenarios use RESET_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, MAX_RETRIES=2.
- Nominal: release RESET; PLL_LOCK=1 from 6 cycles after PLL_RESETB rises → PLL_RESETB low exactly 4 cycles; READY high 11 cycles after lock first sampled; RETRY_COUNT=0.
- Timeout/retry/fault: PLL_LOCK held 0 → PLL_RESETB rises after 4 cycles, falls after 32; RETRY_COUNT=1; second timeout → FAULT=1, PLL_BYPASS=1, PLL_RESETB=0; stays there for 200 cycles.
- Glitch in STABLE: lock high 5 cycles, low 1, then high → READY deferred until 8 consecutive synced-high cycles; no READY pulse.
- Lock loss in RUN: drop PLL_LOCK → READY low 3 edges later, LOST_COUNT=1, PLL_RESETB low 4 cycles, relock → READY again.
- RESTART in FAULT and in RUN → RST_HOLD next cycle; FAULT=0, RETRY_COUNT=0, PLL_BYPASS=0; LOST_COUNT unchanged.
- Async RESET pulse mid-WAIT_LOCK (no clock edge) → PLL_RESETB=0, STATE=0 immediately.
